// File: rtl/irq_cp0.sv
// irq_cp0: CP0 SR/Cause/EPC/PRId registers, interrupt masking and trap/eret sequencing
module irq_cp0 #(
    parameter logic [31:0] PRID = 32'h0000_2018,
    parameter logic [31:0] VEC  = 32'h0000_4180
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  ADDR,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic [5:0]  HWInt,
    input  logic [31:0] VPC,
    input  logic        BD,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCode,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] HandlerPC
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic        hw_hit;
    logic        exc_hit;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign hw_hit    = |(HWInt & im) & ie & ~exl;
    assign exc_hit   = ExcValid & ~exl;
    assign IntReq    = hw_hit | exc_hit;
    assign EPCOut    = epc;
    assign HandlerPC = VEC;
    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

    always_comb begin
        RD = (ADDR == 5'd12) ? sr_val :
             (ADDR == 5'd13) ? cause_val :
             (ADDR == 5'd14) ? epc :
             (ADDR == 5'd15) ? PRID : 32'b0;
    end

    // epc low bits are masked on every write so they stay constant zero
    always_ff @(posedge CLK) begin
        if (RST) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (IntReq) begin
                exl       <= 1'b1;
                epc       <= (BD ? VPC - 32'd4 : VPC) & ~32'd3;
                cause_bd  <= BD;
                cause_exc <= hw_hit ? 5'd0 : ExcCode;
            end else if (EXLClr) begin
                exl <= 1'b0;
            end else if (WE) begin
                if (ADDR == 5'd12) begin
                    im  <= WD[15:10];
                    exl <= WD[1];
                    ie  <= WD[0];
                end
                if (ADDR == 5'd14)
                    epc <= WD & ~32'd3;
            end
        end
    end
endmodule

// File: tb/tb_irq_cp0.sv
// tb_irq_cp0: directed checks of irq_cp0 register access, trap capture and priorities
module tb_irq_cp0;
    localparam logic [31:0] PRID = 32'h0000_2018;
    localparam logic [31:0] VEC  = 32'h0000_4180;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  ADDR = '0;
    logic        WE = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic [5:0]  HWInt = '0;
    logic [31:0] VPC = '0;
    logic        BD = 1'b0;
    logic        ExcValid = 1'b0;
    logic [4:0]  ExcCode = '0;
    logic        EXLClr = 1'b0;
    logic        IntReq;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    int passed = 0;
    int total = 0;

    irq_cp0 #(.PRID(PRID), .VEC(VEC)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .WE(WE), .WD(WD), .RD(RD),
        .HWInt(HWInt), .VPC(VPC), .BD(BD), .ExcValid(ExcValid), .ExcCode(ExcCode),
        .EXLClr(EXLClr), .IntReq(IntReq), .EPCOut(EPCOut), .HandlerPC(HandlerPC)
    );

    always #50 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        ADDR = a;
        #1;
        chk(tag, RD, exp);
    endtask

    task automatic irq(input string tag, input logic exp);
        #1;
        chk(tag, {31'b0, IntReq}, {31'b0, exp});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        ADDR = a; WD = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        tick(); tick();
        RST = 1'b0;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, PRID);
        rd("other_reg", 5'd3, 32'h0);
        chk("handler_pc", HandlerPC, VEC);
        HWInt = 6'h3f; irq("rst_irq_all", 1'b0);
        HWInt = 6'h01; irq("rst_irq_one", 1'b0);
        HWInt = 6'h00;
        mtc0(5'd3, 32'hffff_ffff);
        rd("other_write_ignored", 5'd3, 32'h0);
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_write", 5'd12, 32'h0000_0401);
        irq("no_line", 1'b0);
        HWInt = 6'h01; VPC = 32'h3010;
        irq("irq_rise", 1'b1);
        tick();
        irq("irq_fall_exl", 1'b0);
        rd("trap_sr", 5'd12, 32'h0000_0403);
        rd("trap_epc", 5'd14, 32'h0000_3010);
        rd("trap_cause", 5'd13, 32'h0000_0400);
        chk("trap_epcout", EPCOut, 32'h0000_3010);
        EXLClr = 1'b1;
        irq("eret_cycle", 1'b0);
        tick();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        irq("retrap", 1'b1);
        HWInt = 6'h00; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("retrap_sr", 5'd12, 32'h0000_0401);
        HWInt = 6'h01; BD = 1'b1; VPC = 32'h3014;
        irq("bd_irq", 1'b1);
        tick();
        BD = 1'b0; HWInt = 6'h00;
        chk("bd_epc", EPCOut, 32'h0000_3010);
        rd("bd_cause", 5'd13, 32'h8000_0400);
        EXLClr = 1'b1; tick(); EXLClr = 1'b0;
        HWInt = 6'h01; ExcValid = 1'b1; ExcCode = 5'd4; VPC = 32'h4000;
        tick();
        HWInt = 6'h00; ExcValid = 1'b0;
        rd("int_over_exc_cause", 5'd13, 32'h0000_0400);
        chk("int_over_exc_epc", EPCOut, 32'h0000_4000);
        EXLClr = 1'b1; tick(); EXLClr = 1'b0;
        ExcValid = 1'b1; ExcCode = 5'd4; VPC = 32'h5008;
        irq("exc_irq", 1'b1);
        tick();
        ExcValid = 1'b0;
        rd("exc_cause", 5'd13, 32'h0000_0010);
        chk("exc_epc", EPCOut, 32'h0000_5008);
        rd("exc_sr", 5'd12, 32'h0000_0403);
        ExcValid = 1'b1;
        irq("exc_masked_exl", 1'b0);
        ExcValid = 1'b0;
        EXLClr = 1'b1; tick(); EXLClr = 1'b0;
        ADDR = 5'd14; WD = 32'h0000_1237; WE = 1'b1;
        #1;
        chk("epc_pre_edge", EPCOut, 32'h0000_5008);
        tick();
        WE = 1'b0;
        chk("epc_mtc0", EPCOut, 32'h0000_1234);
        mtc0(5'd12, 32'hffff_ffff);
        rd("sr_fields_only", 5'd12, 32'h0000_fc03);
        mtc0(5'd13, 32'hffff_ffff);
        rd("cause_write_ignored", 5'd13, 32'h0000_0010);
        mtc0(5'd15, 32'h0);
        rd("prid_write_ignored", 5'd15, PRID);
        mtc0(5'd12, 32'h0);
        HWInt = 6'h01;
        irq("ie_off", 1'b0);
        ADDR = 5'd12; WD = 32'h0000_0401; WE = 1'b1;
        irq("ie_write_cycle", 1'b0);
        tick();
        WE = 1'b0;
        irq("ie_next_cycle", 1'b1);
        ADDR = 5'd12; WD = 32'h0; WE = 1'b1;
        tick();
        WE = 1'b0;
        rd("trap_beats_mtc0", 5'd12, 32'h0000_0403);
        HWInt = 6'h00;
        ADDR = 5'd12; WD = 32'h0000_fc01; WE = 1'b1; EXLClr = 1'b1;
        tick();
        WE = 1'b0; EXLClr = 1'b0;
        rd("eret_beats_mtc0", 5'd12, 32'h0000_0401);
        mtc0(5'd12, 32'h0000_0001);
        HWInt = 6'h3f;
        irq("im_zero", 1'b0);
        tick();
        rd("ip_unmasked", 5'd13, 32'h0000_fc00);
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'h01; VPC = 32'h6000;
        irq("pre_reset_irq", 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0; HWInt = 6'h00;
        rd("midtrap_rst_sr", 5'd12, 32'h0);
        rd("midtrap_rst_cause", 5'd13, 32'h0);
        chk("midtrap_rst_epc", EPCOut, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
